// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// the NOP word and the default reset PC.
package if_pkg;
  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sequential successor address; wraps modulo 2^32.
  function automatic logic [31:0] next_seq(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction
endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
//
// Handshake: the master holds imem_req=1 with a stable imem_addr until the
// slave returns a single-cycle imem_ack strobe with imem_rdata valid in that
// same cycle; the slave may ack in the first request cycle or any later one.
interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch_wdog.sv
// Fetch watchdog: counts consecutive request cycles without a response and
// raises a sticky error once TIMEOUT_CYC such cycles have elapsed.
module if_fetch_wdog #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic clear,
  output logic err
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
    end else if (active && (cnt != CW'(TIMEOUT_CYC))) begin
      cnt <= cnt + CW'(1);
      if (cnt == CW'(TIMEOUT_CYC - 1)) err <= 1'b1;
    end
  end
endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: REQ/HOLD/DRAIN controller feeding the IF/ID latch.
// Define IF_FETCH_TIMEOUT_EN to add the fetch watchdog (imem_err).
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [31:0] pc_branch,
  if_fetch_if.master  imem,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic        imem_err,
  output logic [1:0]  state_dbg
);
  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] drain_addr;
  logic        started;
  logic        ack;

  assign ack            = imem.imem_ack;
  // started keeps imem_req low for the whole reset cycle and the first edge after.
  assign imem.imem_req  = started && (state != ST_HOLD);
  assign imem.imem_addr = (state == ST_DRAIN) ? drain_addr : fetch_pc;
  assign state_dbg      = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_REQ;
      fetch_pc    <= RESET_PC;
      drain_addr  <= RESET_PC;
      started     <= 1'b0;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      pc          <= RESET_PC;
      pc_4        <= next_seq(RESET_PC);
    end else begin
      started <= 1'b1;
      if (branch_taken) begin
        fetch_pc    <= pc_branch;
        instr_valid <= 1'b0;
        instr       <= NOP_INSTR;
        if (state == ST_HOLD || ack || (state == ST_REQ && !started)) begin
          state <= ST_REQ;
        end else begin
          // An un-acked request is still in flight; wait for it at its old address.
          state <= ST_DRAIN;
          if (state == ST_REQ) drain_addr <= fetch_pc;
        end
      end else begin
        case (state)
          ST_REQ: begin
            if (ack) begin
              instr       <= imem.imem_rdata;
              pc          <= fetch_pc;
              pc_4        <= next_seq(fetch_pc);
              instr_valid <= 1'b1;
              fetch_pc    <= next_seq(fetch_pc);
              state       <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (pc_write) begin
              instr_valid <= 1'b0;
              instr       <= NOP_INSTR;
              state       <= ST_REQ;
            end
          end
          ST_DRAIN: begin
            if (ack) state <= ST_REQ;
          end
          default: state <= ST_REQ;
        endcase
      end
    end
  end

`ifdef IF_FETCH_TIMEOUT_EN
  if_fetch_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (imem.imem_req),
    .clear  (ack | branch_taken),
    .err    (imem_err)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign imem_err = 1'b0;
`endif
endmodule
